tv_code_sequencer: RTL and testbench
====================================

# tv_code_sequencer

Walks the IR code table stored in the TV codes ROM and replays every code as a modulated IR waveform on one output pin. It sits between the top-level button/trigger logic and the IR LED driver, owning the ROM address bus. It parses per-code headers, times mark/space pairs in tick units, inserts an inter-code gap, and reports completion.

## Interface

- `ROM_SIZE`, 256: ROM depth in bytes; `ADDRESS_BITS = $clog2(ROM_SIZE)`.
- `TICK_CYCLES`, 120: clocks per timing tick (10 µs at 12 MHz).
- `GAP_TICKS`, 25000: silent ticks between consecutive codes.

- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to replay the whole table.
- `abort` in 1: stop immediately; present only with `TV_SEQ_ABORT_EN`.
- `rom_address` out ADDRESS_BITS: registered ROM address.
- `rom_data` in 8: combinational ROM data for `rom_address`.
- `rom_overflow` in 1: ROM address-overflow flag.
- `ir_out` out 1: modulated IR drive, high = LED on.
- `busy` out 1: a replay is in progress.
- `done` out 1: one-cycle pulse when a replay ends.
- `code_index` out 8: number of codes fully emitted in the current or last run.

## Operation

- **ROM format per code:**
  - Byte P: carrier half-period in clocks. A value of 0 is the end-of-table marker.
  - Byte N: pair count. A value of 0 means no pairs, so the code is gap only.
  - Then N pairs of bytes `on`, `off`, each counted in ticks.
- **FSM states:** IDLE, FETCH_P, FETCH_N, FETCH_ON, FETCH_OFF, MARK, SPACE, GAP, FINISH.
- **IDLE:**
  - `start` moves to FETCH_P and sets `rom_address=0`, `code_index=0`.
  - `start` in any other state is ignored.
- **Fetch states:** each lasts exactly 1 cycle. The byte is sampled from `rom_data` and `rom_address` increments.
- **FETCH_P:**
  - P=0 goes to FINISH.
  - Otherwise latch P and go to FETCH_N.
- **FETCH_N:**
  - N=0 goes to GAP.
  - Otherwise latch N into a pair counter and go to FETCH_ON.
- **FETCH_ON → FETCH_OFF → MARK.**
- **MARK:**
  - Lasts `on*TICK_CYCLES` clocks.
  - `ir_out` is 1 on the first MARK clock and toggles every P clocks.
  - `on=0` skips MARK, going straight to SPACE.
- **SPACE:** lasts `off*TICK_CYCLES` clocks with `ir_out=0`. `off=0` skips SPACE. On exit, decrement the pair counter:
  - If pairs remain, go to FETCH_ON.
  - If none remain, go to GAP.
- **GAP:** `GAP_TICKS*TICK_CYCLES` clocks with `ir_out=0`. On exit, increment `code_index` (saturating at 255) and go to FETCH_P.
- **FINISH:** 1 cycle. `done=1`, `busy=0`, then IDLE.
- **End of ROM:** both conditions below go to FINISH instead of proceeding, without consuming the byte:
  - `rom_overflow` high in any fetch state.
  - An address increment that would carry past `ROM_SIZE-1`, tracked by an internal wrap flag. This covers power-of-two ROMs.
- **Counters:**
  - Tick counter is 16 bits.
  - Duration counter is `8+16` bits wide so there is no overflow at on=255.
  - Carrier counter is 8 bits.
- **Idle levels:** `ir_out` is 0 in every state except MARK.

## Timing

- **Reset values:**
  - State IDLE.
  - `rom_address=0`, `ir_out=0`, `busy=0`, `done=0`, `code_index=0`.
- **Start latency:** `start` sampled at edge k gives `busy=1` and `rom_address=0` after edge k, with FETCH_P in cycle k+1.
- **Per-pair overhead:** 2 fetch cycles before MARK. The first pair of a code is additionally preceded by FETCH_P and FETCH_N.
- **`busy`:**
  - High from the cycle after `start` through the last GAP/fetch cycle.
  - Low in the FINISH cycle, which carries the `done` pulse.
- **Reset mid-run:** immediate return to reset values, since reset is asynchronous.
- **Simultaneous `start` and FINISH:** `start` is ignored; a new `start` is required in IDLE.

## Configuration

- **`TV_SEQ_ABORT_EN` defined:**
  - The `abort` port exists.
  - `abort=1` in any non-IDLE state goes to FINISH on the next edge: `ir_out=0` there, `done` pulses once, and `code_index` is unchanged.
  - `abort` wins over every other transition.
- **Undefined:** no `abort` port; a run always ends by end marker or ROM end.

## Test plan

Common settings: `TICK_CYCLES=4`, `GAP_TICKS=2`.

1. **Single pair.** ROM `{03,01,02,01,00}` + `start` → FETCH_P, FETCH_N, FETCH_ON, FETCH_OFF; then `ir_out` high 3 clocks, low 3, high 2 (8 MARK clocks); 4 clocks low; 8 gap clocks; `code_index=1`; `done` pulse; `busy` drops.
2. **Two codes.** ROM `{02,02,01,01,01,00,05,01,01,01,00}` → MARK toggles every 2 clocks in code 0 and every 5 in code 1; `code_index` ends at 2; exactly one `done`.
3. **Zero fields.** ROM `{04,00,00}` → no MARK, `ir_out` stays 0, 8 gap clocks, `code_index=1`. ROM `{04,01,00,03,00}` → MARK skipped, 12-clock SPACE.
4. **ROM end without marker.** `ROM_SIZE=4`, ROM `{02,01,01,01}` → after the pair, GAP, then the wrap flag forces FINISH; `done` pulses; `rom_address` never presents a fifth fetch.
5. **Reset and ignored start.** Assert `rst` mid-MARK → `ir_out=0`, `busy=0`, `code_index=0` immediately. A `start` pulse during GAP → no restart, and the run completes normally.
6. **Abort (`TV_SEQ_ABORT_EN`).** `abort` in the 2nd MARK clock → next cycle FINISH, `ir_out=0`, `done=1`, `code_index=0`.

Source files
------------

// File: rtl/tv_code_sequencer.sv
// IR code table sequencer: walks the codes ROM and replays each code as a carrier-modulated
// mark/space waveform with an inter-code gap. Optional abort input under TV_SEQ_ABORT_EN.
module tv_code_sequencer #(
    parameter int unsigned ROM_SIZE     = 256,
    parameter int unsigned ADDRESS_BITS = $clog2(ROM_SIZE),
    parameter int unsigned TICK_CYCLES  = 120,
    parameter int unsigned GAP_TICKS    = 25000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
`ifdef TV_SEQ_ABORT_EN
    input  logic                    abort,
`endif
    output logic [ADDRESS_BITS-1:0] rom_address,
    input  logic [7:0]              rom_data,
    input  logic                    rom_overflow,
    output logic                    ir_out,
    output logic                    busy,
    output logic                    done,
    output logic [7:0]              code_index
);

    typedef enum logic [3:0] {
        StIdle, StFetchP, StFetchN, StFetchOn, StFetchOff, StMark, StSpace, StGap, StFinish
    } state_e;

    localparam logic [15:0]             TickLast = 16'(TICK_CYCLES - 1);
    localparam logic [23:0]             GapTicks = 24'(GAP_TICKS);
    localparam logic [ADDRESS_BITS-1:0] AddrLast = ADDRESS_BITS'(ROM_SIZE - 1);

    state_e                  state_q, state_d;
    logic [ADDRESS_BITS-1:0] addr_q, addr_d;
    logic                    wrap_q, wrap_d;
    logic [7:0]              p_q, p_d;
    logic [7:0]              pairs_q, pairs_d;
    logic [7:0]              on_q, on_d;
    logic [7:0]              off_q, off_d;
    logic [15:0]             tick_q, tick_d;
    logic [23:0]             dur_q, dur_d;
    logic [7:0]              car_cnt_q, car_cnt_d;
    logic                    car_q, car_d;
    logic [7:0]              code_index_q, code_index_d;

    logic is_fetch, fetch_ok, phase_end, pair_done;

    assign is_fetch  = (state_q == StFetchP) || (state_q == StFetchN) ||
                       (state_q == StFetchOn) || (state_q == StFetchOff);
    // Wrap flag marks that the last ROM byte was already consumed.
    assign fetch_ok  = !rom_overflow && !wrap_q;
    assign phase_end = (tick_q == TickLast) && (dur_q == 24'd1);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wrap_d       = wrap_q;
        p_d          = p_q;
        pairs_d      = pairs_q;
        on_d         = on_q;
        off_d        = off_q;
        tick_d       = tick_q;
        dur_d        = dur_q;
        car_cnt_d    = car_cnt_q;
        car_d        = car_q;
        code_index_d = code_index_q;
        pair_done    = 1'b0;

        if (state_q == StMark || state_q == StSpace || state_q == StGap) begin
            if (tick_q == TickLast) begin
                tick_d = 16'd0;
                dur_d  = dur_q - 24'd1;
            end else begin
                tick_d = tick_q + 16'd1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d      = StFetchP;
                    addr_d       = '0;
                    wrap_d       = 1'b0;
                    code_index_d = 8'd0;
                end
            end
            StFetchP: begin
                if (!fetch_ok || rom_data == 8'd0) begin
                    state_d = StFinish;
                end else begin
                    p_d     = rom_data;
                    state_d = StFetchN;
                end
            end
            StFetchN: begin
                if (!fetch_ok) begin
                    state_d = StFinish;
                end else if (rom_data == 8'd0) begin
                    state_d = StGap;
                    tick_d  = 16'd0;
                    dur_d   = GapTicks;
                end else begin
                    pairs_d = rom_data;
                    state_d = StFetchOn;
                end
            end
            StFetchOn: begin
                if (!fetch_ok) begin
                    state_d = StFinish;
                end else begin
                    on_d    = rom_data;
                    state_d = StFetchOff;
                end
            end
            StFetchOff: begin
                if (!fetch_ok) begin
                    state_d = StFinish;
                end else begin
                    off_d = rom_data;
                    if (on_q != 8'd0) begin
                        state_d   = StMark;
                        tick_d    = 16'd0;
                        dur_d     = 24'(on_q);
                        car_d     = 1'b1;
                        car_cnt_d = 8'd0;
                    end else if (rom_data != 8'd0) begin
                        state_d = StSpace;
                        tick_d  = 16'd0;
                        dur_d   = 24'(rom_data);
                    end else begin
                        pair_done = 1'b1;
                    end
                end
            end
            StMark: begin
                if (car_cnt_q == p_q - 8'd1) begin
                    car_cnt_d = 8'd0;
                    car_d     = ~car_q;
                end else begin
                    car_cnt_d = car_cnt_q + 8'd1;
                end
                if (phase_end) begin
                    if (off_q != 8'd0) begin
                        state_d = StSpace;
                        tick_d  = 16'd0;
                        dur_d   = 24'(off_q);
                    end else begin
                        pair_done = 1'b1;
                    end
                end
            end
            StSpace: begin
                if (phase_end) pair_done = 1'b1;
            end
            StGap: begin
                if (phase_end) begin
                    state_d = StFetchP;
                    if (code_index_q != 8'hff) code_index_d = code_index_q + 8'd1;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        if (pair_done) begin
            pairs_d = pairs_q - 8'd1;
            if (pairs_q == 8'd1) begin
                state_d = StGap;
                tick_d  = 16'd0;
                dur_d   = GapTicks;
            end else begin
                state_d = StFetchOn;
            end
        end

        if (is_fetch && fetch_ok) begin
            if (addr_q == AddrLast) wrap_d = 1'b1;
            else                    addr_d = addr_q + 1'b1;
        end

`ifdef TV_SEQ_ABORT_EN
        if (abort && state_q != StIdle && state_q != StFinish) begin
            state_d      = StFinish;
            code_index_d = code_index_q;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            wrap_q       <= 1'b0;
            p_q          <= 8'd0;
            pairs_q      <= 8'd0;
            on_q         <= 8'd0;
            off_q        <= 8'd0;
            tick_q       <= 16'd0;
            dur_q        <= 24'd0;
            car_cnt_q    <= 8'd0;
            car_q        <= 1'b0;
            code_index_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wrap_q       <= wrap_d;
            p_q          <= p_d;
            pairs_q      <= pairs_d;
            on_q         <= on_d;
            off_q        <= off_d;
            tick_q       <= tick_d;
            dur_q        <= dur_d;
            car_cnt_q    <= car_cnt_d;
            car_q        <= car_d;
            code_index_q <= code_index_d;
        end
    end

    assign rom_address = addr_q;
    assign ir_out      = (state_q == StMark) && car_q;
    assign busy        = (state_q != StIdle) && (state_q != StFinish);
    assign done        = (state_q == StFinish);
    assign code_index  = code_index_q;

endmodule

// File: tb/tb_tv_code_sequencer.sv
// Directed bench for tv_code_sequencer: a 256-byte ROM instance and a 4-byte ROM instance
// for the end-of-ROM case, TICK_CYCLES=4, GAP_TICKS=2.
module tb_tv_code_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic ovf = 1'b0;
    logic sel = 1'b0;
`ifdef TV_SEQ_ABORT_EN
    logic abort = 1'b0;
`endif

    logic [7:0] rom  [256];
    logic [7:0] rom4 [4];

    logic [7:0] addr0, data0, ci0, ci4;
    logic [1:0] addr4;
    logic [7:0] data4;
    logic       ir0, busy0, done0, ir4, busy4, done4;

    assign data0 = rom[addr0];
    assign data4 = rom4[addr4];

    tv_code_sequencer #(.ROM_SIZE(256), .TICK_CYCLES(4), .GAP_TICKS(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start & ~sel),
`ifdef TV_SEQ_ABORT_EN
        .abort        (abort),
`endif
        .rom_address  (addr0),
        .rom_data     (data0),
        .rom_overflow (ovf),
        .ir_out       (ir0),
        .busy         (busy0),
        .done         (done0),
        .code_index   (ci0)
    );

    tv_code_sequencer #(.ROM_SIZE(4), .TICK_CYCLES(4), .GAP_TICKS(2)) dut4 (
        .clk          (clk),
        .rst          (rst),
        .start        (start & sel),
`ifdef TV_SEQ_ABORT_EN
        .abort        (1'b0),
`endif
        .rom_address  (addr4),
        .rom_data     (data4),
        .rom_overflow (1'b0),
        .ir_out       (ir4),
        .busy         (busy4),
        .done         (done4),
        .code_index   (ci4)
    );

    logic       ir_m, busy_m, done_m;
    logic [7:0] ci_m, addr_m;

    always_comb begin
        if (sel) begin
            ir_m = ir4; busy_m = busy4; done_m = done4; ci_m = ci4; addr_m = {6'd0, addr4};
        end else begin
            ir_m = ir0; busy_m = busy0; done_m = done0; ci_m = ci0; addr_m = addr0;
        end
    end

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [63:0] ir_bits, busy_bits;
    int          done_cnt, done_cyc;
    logic [7:0]  addr_t [64];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        for (int i = 0; i < 4; i++) rom4[i] = 8'h00;
    endtask

    // Pulses start, then records outputs for cycles 1..ncyc after the start edge;
    // a second start is raised in cycle inj (0 = none).
    task automatic run(input int ncyc, input int inj);
        ir_bits = '0; busy_bits = '0; done_cnt = 0; done_cyc = -1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            ir_bits[c]   = ir_m;
            busy_bits[c] = busy_m;
            addr_t[c]    = addr_m;
            if (done_m) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            start = (c == inj);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        clear_rom();
        repeat (2) @(negedge clk);
        check("reset_ir", 64'(ir0), 64'd0);
        check("reset_busy", 64'(busy0), 64'd0);
        check("reset_done", 64'(done0), 64'd0);
        check("reset_code_index", 64'(ci0), 64'd0);
        check("reset_addr", 64'(addr0), 64'd0);
        check("reset_addr4", 64'(addr4), 64'd0);
        rst = 1'b0;

        // Single pair, P=3
        rom[0] = 8'h03; rom[1] = 8'h01; rom[2] = 8'h02; rom[3] = 8'h01;
        run(40, 0);
        check("t1_ir", ir_bits, (64'd1 << 5) | (64'd1 << 6) | (64'd1 << 7) |
                                (64'd1 << 11) | (64'd1 << 12));
        check("t1_busy", busy_bits, (64'd1 << 26) - 64'd2);
        check("t1_done_cycle", 64'(done_cyc), 64'd26);
        check("t1_done_count", 64'(done_cnt), 64'd1);
        check("t1_addr_c1", 64'(addr_t[1]), 64'd0);
        check("t1_addr_c2", 64'(addr_t[2]), 64'd1);
        check("t1_addr_mark", 64'(addr_t[5]), 64'd4);
        check("t1_code_index", 64'(ci0), 64'd1);

        // Two codes
        clear_rom();
        rom[0] = 8'h02; rom[1] = 8'h02; rom[2] = 8'h01; rom[3] = 8'h01; rom[4] = 8'h01;
        rom[5] = 8'h00; rom[6] = 8'h05; rom[7] = 8'h01; rom[8] = 8'h01; rom[9] = 8'h01;
        run(60, 0);
        check("t2_ir", ir_bits, (64'd1 << 5) | (64'd1 << 6) | (64'd1 << 15) | (64'd1 << 16) |
                                (64'd1 << 31) | (64'd1 << 32) | (64'd1 << 33) | (64'd1 << 34));
        check("t2_busy", busy_bits, (64'd1 << 48) - 64'd2);
        check("t2_done_cycle", 64'(done_cyc), 64'd48);
        check("t2_done_count", 64'(done_cnt), 64'd1);
        check("t2_code_index", 64'(ci0), 64'd2);

        // Zero pair count: gap only
        clear_rom();
        rom[0] = 8'h04;
        run(30, 0);
        check("t3a_ir", ir_bits, 64'd0);
        check("t3a_done_cycle", 64'(done_cyc), 64'd12);
        check("t3a_code_index", 64'(ci0), 64'd1);

        // on=0: MARK skipped, 12-clock SPACE
        clear_rom();
        rom[0] = 8'h04; rom[1] = 8'h01; rom[2] = 8'h00; rom[3] = 8'h03;
        run(30, 0);
        check("t3b_ir", ir_bits, 64'd0);
        check("t3b_done_cycle", 64'(done_cyc), 64'd26);
        check("t3b_code_index", 64'(ci0), 64'd1);

        // ROM end without marker on the 4-byte instance
        clear_rom();
        rom4[0] = 8'h02; rom4[1] = 8'h01; rom4[2] = 8'h01; rom4[3] = 8'h01;
        sel = 1'b1;
        run(30, 0);
        check("t4_ir", ir_bits, (64'd1 << 5) | (64'd1 << 6));
        check("t4_done_cycle", 64'(done_cyc), 64'd22);
        check("t4_done_count", 64'(done_cnt), 64'd1);
        check("t4_addr_held", 64'(addr_t[21]), 64'd3);
        check("t4_code_index", 64'(ci4), 64'd1);
        sel = 1'b0;

        // rom_overflow on the first fetch
        clear_rom();
        rom[0] = 8'h03; rom[1] = 8'h01; rom[2] = 8'h02; rom[3] = 8'h01;
        ovf = 1'b1;
        run(10, 0);
        check("ovf_done_cycle", 64'(done_cyc), 64'd2);
        check("ovf_code_index", 64'(ci0), 64'd0);
        ovf = 1'b0;

        // Asynchronous reset during the second code's MARK
        clear_rom();
        rom[0] = 8'h02; rom[1] = 8'h02; rom[2] = 8'h01; rom[3] = 8'h01; rom[4] = 8'h01;
        rom[5] = 8'h00; rom[6] = 8'h05; rom[7] = 8'h01; rom[8] = 8'h01; rom[9] = 8'h01;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (30) @(negedge clk);
        check("t5_pre_ir", 64'(ir0), 64'd1);
        check("t5_pre_code_index", 64'(ci0), 64'd1);
        rst = 1'b1;
        #1;
        check("t5_rst_ir", 64'(ir0), 64'd0);
        check("t5_rst_busy", 64'(busy0), 64'd0);
        check("t5_rst_code_index", 64'(ci0), 64'd0);
        check("t5_rst_addr", 64'(addr0), 64'd0);
        @(negedge clk); rst = 1'b0;

        // start during GAP is ignored
        clear_rom();
        rom[0] = 8'h03; rom[1] = 8'h01; rom[2] = 8'h02; rom[3] = 8'h01;
        run(40, 20);
        check("t5_gap_start_done_cycle", 64'(done_cyc), 64'd26);
        check("t5_gap_start_done_count", 64'(done_cnt), 64'd1);
        check("t5_gap_start_busy", busy_bits, (64'd1 << 26) - 64'd2);

        // start coinciding with FINISH is ignored
        run(40, 26);
        check("t5_fin_start_busy", busy_bits, (64'd1 << 26) - 64'd2);
        check("t5_fin_start_done_count", 64'(done_cnt), 64'd1);

`ifdef TV_SEQ_ABORT_EN
        // abort in the second MARK clock
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_pre_ir", 64'(ir0), 64'd1);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check("t6_ir", 64'(ir0), 64'd0);
        check("t6_done", 64'(done0), 64'd1);
        check("t6_busy", 64'(busy0), 64'd0);
        check("t6_code_index", 64'(ci0), 64'd0);
        @(negedge clk);
        check("t6_done_once", 64'(done0), 64'd0);
        check("t6_idle_busy", 64'(busy0), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
